snitch_icache_lookup_sched: RTL

Request scheduler in front of the serial instruction-cache lookup. It shares the single lookup request port between `NR_REQ` fetch requesters with a locked round-robin arbiter, and tags each request with the requester index. It routes lookup responses back by that tag, bounds outstanding lookups, and sequences cache flushes: admission stops, the pipeline drains, then the flush handshake is issued.

---
 rtl/snitch_icache_lookup_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/snitch_icache_lookup_sched.sv
// Lookup request scheduler: locked round-robin arbitration onto the serial lookup
// port, tag-based response routing, inflight bounding and flush sequencing.
module snitch_icache_lookup_sched #(
  parameter int unsigned NR_REQ       = 4,
  parameter int unsigned FETCH_AW     = 32,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned IdxW  = $clog2(NR_REQ),
  localparam int unsigned LkIdW = ID_WIDTH + IdxW,
  localparam int unsigned CntW  = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_REQ-1:0][FETCH_AW-1:0]    req_addr_i,
  input  logic [NR_REQ-1:0][ID_WIDTH-1:0]    req_id_i,
  input  logic [NR_REQ-1:0]                  req_valid_i,
  output logic [NR_REQ-1:0]                  req_ready_o,
  output logic [LINE_WIDTH-1:0]              rsp_data_o,
  output logic                               rsp_hit_o,
  output logic                               rsp_error_o,
  output logic [ID_WIDTH-1:0]                rsp_id_o,
  output logic [NR_REQ-1:0]                  rsp_valid_o,
  input  logic [NR_REQ-1:0]                  rsp_ready_i,
  output logic [FETCH_AW-1:0]                lk_addr_o,
  output logic [LkIdW-1:0]                   lk_id_o,
  output logic                               lk_valid_o,
  input  logic                               lk_ready_i,
  input  logic [LINE_WIDTH-1:0]              lk_data_i,
  input  logic                               lk_hit_i,
  input  logic                               lk_error_i,
  input  logic [LkIdW-1:0]                   lk_id_i,
  input  logic                               lk_valid_i,
  output logic                               lk_ready_o,
  input  logic                               flush_valid_i,
  output logic                               flush_ready_o,
  output logic                               lk_flush_valid_o,
  input  logic                               lk_flush_ready_i,
  output logic                               busy_o
);

  typedef enum logic [1:0] {StRun, StDrain, StFlush} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, gnt_q, gnt_idx, idx;
  logic              lock_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NR_REQ-1:0] elig;
  logic              any_elig, req_hs, rsp_hs, sel_legal;
  logic [IdxW-1:0]   sel;

  // Grant selection: held grant while locked, else first eligible at/after rr_q
  always_comb begin
    elig     = req_valid_i & {NR_REQ{cnt_q < CntW'(MAX_INFLIGHT)}};
    gnt_idx  = gnt_q;
    any_elig = 1'b0;
    idx      = '0;
    if (lock_q) begin
      any_elig = req_valid_i[gnt_q];
    end else begin
      for (int unsigned k = 0; k < NR_REQ; k++) begin
        idx = IdxW'((32'(rr_q) + k) % NR_REQ);
        if (!any_elig && elig[idx]) begin
          any_elig = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

  assign lk_addr_o = req_addr_i[gnt_idx];
  assign lk_id_o   = {gnt_idx, req_id_i[gnt_idx]};

  // Response routing by the requester index carried in the upper ID bits
  assign sel         = lk_id_i[LkIdW-1:ID_WIDTH];
  assign sel_legal   = 32'(sel) < NR_REQ;
  assign rsp_id_o    = lk_id_i[ID_WIDTH-1:0];
  assign rsp_data_o  = lk_data_i;
  assign rsp_hit_o   = lk_hit_i;
  assign rsp_error_o = lk_error_i;
  assign lk_ready_o  = sel_legal ? rsp_ready_i[sel] : 1'b1;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      rsp_valid_o[i] = lk_valid_i & sel_legal & (sel == IdxW'(i));
    end
  end

  assign req_hs = lk_valid_o & lk_ready_i;
  assign rsp_hs = lk_valid_i & lk_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs && !rsp_hs && cnt_q != CntW'(MAX_INFLIGHT)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!req_hs && rsp_hs && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  assign busy_o = (state_q != StRun) || (cnt_q != '0);

  // Arbitration bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_idx;
      lock_q <= lk_valid_o & ~lk_ready_i;
      if (req_hs) rr_q <= IdxW'((32'(gnt_idx) + 32'd1) % NR_REQ);
    end
  end

  // Flush FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StRun;
    else         state_q <= state_d;
  end

  // Flush FSM: next state; a pending locked handshake defers the drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_valid_i && !lock_q) state_d = StDrain;
      StDrain: if (cnt_d == '0)              state_d = StFlush;
      StFlush: if (lk_flush_ready_i)         state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Flush FSM: outputs
  always_comb begin
    lk_valid_o       = 1'b0;
    req_ready_o      = '0;
    lk_flush_valid_o = 1'b0;
    flush_ready_o    = 1'b0;
    unique case (state_q)
      StRun: begin
        lk_valid_o           = any_elig;
        req_ready_o[gnt_idx] = any_elig & lk_ready_i;
      end
      StFlush: begin
        lk_flush_valid_o = 1'b1;
        flush_ready_o    = lk_flush_ready_i;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_sel_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lk_valid_i |-> sel_legal)
    else $error("lookup response carries an out-of-range requester index");
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_hs |-> (cnt_q != '0))
    else $error("lookup response with no lookup outstanding");
`endif

endmodule
